uart_tx: RTL and testbench

UART transmitter that serialises bytes from an AXI-Stream-style input onto a single TX line. Frame: 1 start bit (0), DATA_WIDTH data bits LSB first, optional parity bit, then 1 or 2 stop bits (1). Bit timing matches the team's UART receiver: one bit = PRESCALE*8 clk cycles, so a receiver and transmitter pair built with the same PRESCALE interoperate. Sits between host-side byte FIFOs/command logic and the board UART pin.

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_bit_timer.sv | 38 +++
 rtl/uart_tx.sv | 174 +++++++++++++++++
 tb/tb_uart_tx.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter/receiver pair: line-format enums,
// timer sizing and the bit-period helper both directions must agree on.
package uart_pkg;

    localparam int PRESCALE_W = 19;
    localparam int BIT_CNT_W  = 4;
    localparam int MAX_DATA_W = 9;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_ODD  = 2'd1,
        PARITY_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    // One bit lasts prescale*8 clk cycles; a 16-bit prescale fits exactly in 19 bits.
    function automatic logic [PRESCALE_W-1:0] bit_period(input logic [15:0] prescale);
        return {prescale, 3'b000};
    endfunction

    // Unused upper data bits are zero, so they never disturb the XOR.
    function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data, input parity_e mode);
        logic p;
        p = 1'b0;
        case (mode)
            PARITY_EVEN: p = ^data;
            PARITY_ODD:  p = ~^data;
            default:     p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter producing a one-cycle "done" indication when an enabled
// count reaches zero; shared bit-timing primitive for the UART blocks.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int W = PRESCALE_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    assign done = en && (count_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts one word per valid/ready handshake and shifts out
// start, data (LSB first), optional parity and stop bits on a registered txd.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 500,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] tdata,
    input  logic                  tvalid,
    output logic                  tready,
    output logic                  txd,
    output logic                  busy
);

    generate
        if (DATA_WIDTH < 5 || DATA_WIDTH > MAX_DATA_W) begin : g_bad_data_width
            $fatal(1, "uart_tx: DATA_WIDTH must be 5..9");
        end
        if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
            $fatal(1, "uart_tx: PRESCALE must be 1..65535");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $fatal(1, "uart_tx: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $fatal(1, "uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    localparam parity_e                PAR_MODE  = parity_e'(PARITY);
    localparam logic [PRESCALE_W-1:0]  BIT_LAST  = bit_period(16'(PRESCALE)) - 19'd1;
    localparam logic [BIT_CNT_W-1:0]   DATA_LAST = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0]   STOP_LAST = BIT_CNT_W'(STOP_BITS - 1);

    tx_state_e               state_q,   state_d;
    logic                    txd_q,     txd_d;
    logic                    busy_q,    busy_d;
    logic                    tready_q,  tready_d;
    logic [DATA_WIDTH-1:0]   shift_q,   shift_d;
    logic                    par_q,     par_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;

    logic timer_load;
    logic timer_done;

    uart_bit_timer #(
        .W (PRESCALE_W)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (state_q != TX_IDLE),
        .load     (timer_load),
        .load_val (BIT_LAST),
        .done     (timer_done)
    );

    always_comb begin
        state_d    = state_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        tready_d   = tready_q;
        shift_d    = shift_q;
        par_d      = par_q;
        bit_cnt_d  = bit_cnt_q;
        timer_load = 1'b0;

        case (state_q)
            TX_IDLE: begin
                txd_d    = 1'b1;
                busy_d   = 1'b0;
                tready_d = 1'b1;
                if (tvalid && tready_q) begin
                    shift_d    = tdata;
                    par_d      = parity_bit(MAX_DATA_W'(tdata), PAR_MODE);
                    timer_load = 1'b1;
                    state_d    = TX_START;
                    txd_d      = 1'b0;
                    busy_d     = 1'b1;
                    tready_d   = 1'b0;
                end
            end

            TX_START: begin
                if (timer_done) begin
                    timer_load = 1'b1;
                    state_d    = TX_DATA;
                    txd_d      = shift_q[0];
                    shift_d    = shift_q >> 1;
                    bit_cnt_d  = DATA_LAST;
                end
            end

            // bit_cnt_q counts the data bits still to follow the one on the line.
            TX_DATA: begin
                if (timer_done) begin
                    timer_load = 1'b1;
                    if (bit_cnt_q != '0) begin
                        txd_d     = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
                    end else if (PAR_MODE != PARITY_NONE) begin
                        state_d = TX_PARITY;
                        txd_d   = par_q;
                    end else begin
                        state_d   = TX_STOP;
                        txd_d     = 1'b1;
                        bit_cnt_d = STOP_LAST;
                    end
                end
            end

            TX_PARITY: begin
                if (timer_done) begin
                    timer_load = 1'b1;
                    state_d    = TX_STOP;
                    txd_d      = 1'b1;
                    bit_cnt_d  = STOP_LAST;
                end
            end

            // The extra idle cycle after the last stop bit comes from IDLE itself.
            TX_STOP: begin
                if (timer_done) begin
                    if (bit_cnt_q != '0) begin
                        timer_load = 1'b1;
                        bit_cnt_d  = bit_cnt_q - BIT_CNT_W'(1);
                    end else begin
                        state_d  = TX_IDLE;
                        busy_d   = 1'b0;
                        tready_d = 1'b1;
                        txd_d    = 1'b1;
                    end
                end
            end

            default: begin
                state_d  = TX_IDLE;
                txd_d    = 1'b1;
                busy_d   = 1'b0;
                tready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= TX_IDLE;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            tready_q  <= 1'b0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            tready_q  <= tready_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign txd    = txd_q;
    assign busy   = busy_q;
    assign tready = tready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four differently configured instances driven with directed
// and random bytes, each frame compared cycle-by-cycle with a bit-list model.
module tb_uart_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] tdata_a  [4];
    logic       tvalid_a [4];
    logic       tready_a [4];
    logic       txd_a    [4];
    logic       busy_a   [4];

    int presc_t [4] = '{1, 1, 1, 2};
    int par_t   [4] = '{0, 2, 1, 0};
    int stop_t  [4] = '{1, 1, 1, 2};

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx #(.DATA_WIDTH(8), .PRESCALE(1), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .tdata(tdata_a[0]), .tvalid(tvalid_a[0]),
        .tready(tready_a[0]), .txd(txd_a[0]), .busy(busy_a[0]));
    uart_tx #(.DATA_WIDTH(8), .PRESCALE(1), .PARITY(2), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tdata(tdata_a[1]), .tvalid(tvalid_a[1]),
        .tready(tready_a[1]), .txd(txd_a[1]), .busy(busy_a[1]));
    uart_tx #(.DATA_WIDTH(8), .PRESCALE(1), .PARITY(1), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .tdata(tdata_a[2]), .tvalid(tvalid_a[2]),
        .tready(tready_a[2]), .txd(txd_a[2]), .busy(busy_a[2]));
    uart_tx #(.DATA_WIDTH(8), .PRESCALE(2), .PARITY(0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .tdata(tdata_a[3]), .tvalid(tvalid_a[3]),
        .tready(tready_a[3]), .txd(txd_a[3]), .busy(busy_a[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a negedge with tdata/tvalid already presented and tready high.
    task automatic do_frame(input int k, input logic [7:0] data, input bit chain, input logic [7:0] nxt);
        int           q[$];
        int           bp, fl, len;
        logic [255:0] ex_txd, ex_busy, ex_rdy, ob_txd, ob_busy, ob_rdy;
        logic [7:0]   rx;

        bp = presc_t[k] * 8;
        q.push_back(0);
        for (int b = 0; b < 8; b++) q.push_back(data[b] ? 1 : 0);
        if (par_t[k] == 2) q.push_back((^data) ? 1 : 0);
        if (par_t[k] == 1) q.push_back((^data) ? 0 : 1);
        for (int s = 0; s < stop_t[k]; s++) q.push_back(1);
        fl  = q.size() * bp;
        len = fl + 1;

        ex_txd = '0; ex_busy = '0; ex_rdy = '0;
        ob_txd = '0; ob_busy = '0; ob_rdy = '0;
        for (int i = 0; i < len; i++) begin
            ex_txd[i]  = (i < fl) ? (q[i / bp] != 0) : 1'b1;
            ex_busy[i] = (i < fl);
            ex_rdy[i]  = (i >= fl);
        end

        @(posedge clk);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            ob_txd[i]  = txd_a[k];
            ob_busy[i] = busy_a[k];
            ob_rdy[i]  = tready_a[k];
            if (i < fl - 1) begin
                tvalid_a[k] = 1'($urandom_range(0, 1));
                tdata_a[k]  = 8'($urandom);
            end else if (i == fl - 1) begin
                tvalid_a[k] = chain;
                tdata_a[k]  = chain ? nxt : 8'($urandom);
            end
        end

        for (int b = 0; b < 8; b++) rx[b] = ob_txd[(b + 1) * bp + bp / 2];

        check_eq($sformatf("i%0d_txd_%02h", k, data), ob_txd, ex_txd);
        check_eq($sformatf("i%0d_busy_%02h", k, data), ob_busy, ex_busy);
        check_eq($sformatf("i%0d_tready_%02h", k, data), ob_rdy, ex_rdy);
        check_eq($sformatf("i%0d_rxbyte_%02h", k, data), 256'(rx), 256'(data));
        $display("inst%0d sent %02h frame %0d clk chain %0d", k, data, fl, chain);
    endtask

    task automatic start_frame(input int k, input logic [7:0] data, input bit chain, input logic [7:0] nxt);
        int c;
        c = 0;
        while (tready_a[k] !== 1'b1 && c < 300) begin
            @(negedge clk);
            c++;
        end
        check_eq($sformatf("i%0d_ready_wait", k), 256'(tready_a[k]), 256'(1));
        tdata_a[k]  = data;
        tvalid_a[k] = 1'b1;
        do_frame(k, data, chain, nxt);
    endtask

    initial begin
        logic [7:0] b0, b1, b2;

        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tdata_a[k]  = 8'h00;
            tvalid_a[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("i%0d_rst_txd", k), 256'(txd_a[k]), 256'(1));
            check_eq($sformatf("i%0d_rst_busy", k), 256'(busy_a[k]), 256'(0));
            check_eq($sformatf("i%0d_rst_tready", k), 256'(tready_a[k]), 256'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++)
            check_eq($sformatf("i%0d_tready_after_rst", k), 256'(tready_a[k]), 256'(1));

        // Directed single byte, then a held-valid pair, then a random stream.
        start_frame(0, 8'hA5, 1'b0, 8'h00);
        start_frame(0, 8'h00, 1'b1, 8'hFF);
        do_frame(0, 8'hFF, 1'b0, 8'h00);
        b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
        start_frame(0, b0, 1'b1, b1);
        do_frame(0, b1, 1'b1, b2);
        do_frame(0, b2, 1'b0, 8'h00);

        for (int k = 1; k < 4; k++) begin
            start_frame(k, (k == 3) ? 8'h01 : 8'hA5, 1'b0, 8'h00);
            for (int r = 0; r < 2; r++) start_frame(k, 8'($urandom), 1'b0, 8'h00);
        end

        // Abandon a frame 30 clk in while txd is driving a 0 data bit.
        tdata_a[0]  = 8'h5A;
        tvalid_a[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tvalid_a[0] = 1'b0;
        repeat (29) @(negedge clk);
        check_eq("i0_midframe_txd", 256'(txd_a[0]), 256'(0));
        #2 rst_n = 1'b0;
        #1;
        check_eq("i0_async_rst_txd", 256'(txd_a[0]), 256'(1));
        check_eq("i0_async_rst_busy", 256'(busy_a[0]), 256'(0));
        check_eq("i0_async_rst_tready", 256'(tready_a[0]), 256'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("i0_tready_after_rerst", 256'(tready_a[0]), 256'(1));
        start_frame(0, 8'h3C, 1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
